// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding, stage amount table and default sizes for the shift sequencer
package shift_seq_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Stage k shifts by STAGE_AMT[k]; largest stage first.
    localparam int STAGE_AMT [DEF_SHAMT_W] = '{16, 8, 4, 2, 1};

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// rtl/shift_seq_ctrl_if.sv - request/result bundle between a shift requester and shift_seq_ctrl
interface shift_seq_ctrl_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
);
    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               ctrl_shiftdirection;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   data_out;

    modport master (
        output start, data_in, shamt, ctrl_shiftdirection,
        input  busy, done, data_out
    );

    modport slave (
        input  start, data_in, shamt, ctrl_shiftdirection,
        output busy, done, data_out
    );
endinterface

// File: rtl/shift_stage_ena.sv
// rtl/shift_stage_ena.sv - one fixed-amount shift stage; passes input through when ena is low
module shift_stage_ena #(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             ena,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);
    localparam logic [WIDTH-1:0] HI_MASK = ~({WIDTH{1'b1}} >> AMT);

    always_comb begin
        dout = din;
        if (ena) begin
            if (dir) begin
                dout = (din >> AMT) | (fill ? HI_MASK : '0);
            end else begin
                dout = din << AMT;
            end
        end
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle 16/8/4/2/1 shift sequencer; SHIFT_SEQ_ARITH_EN selects arithmetic right shift
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    shift_seq_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(SHAMT_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               dir_q, dir_d;
    logic [WIDTH-1:0]   dout_q, dout_d;

    logic               fill;
    logic [WIDTH-1:0]   stage_out [SHAMT_W];
    logic [WIDTH-1:0]   shifted;

`ifdef SHIFT_SEQ_ARITH_EN
    // Right shifts preserve the MSB, so the working reg's MSB stays equal to the latched operand's.
    assign fill = work_q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage_ena #(
            .WIDTH (WIDTH),
            .AMT   (STAGE_AMT[k])
        ) u_stage (
            .din  (work_q),
            .ena  (shamt_q[SHAMT_W-1-k]),
            .dir  (dir_q),
            .fill (fill),
            .dout (stage_out[k])
        );
    end

    always_comb begin
        shifted = work_q;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (cnt_q == CNT_W'(k)) shifted = stage_out[k];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        dir_d   = dir_q;
        dout_d  = dout_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    work_d  = bus.data_in;
                    shamt_d = bus.shamt;
                    dir_d   = bus.ctrl_shiftdirection;
                end
            end
            SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SHAMT_W - 1)) begin
                    state_d = DONE;
                    dout_d  = shifted;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            shamt_q <= '0;
            dir_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.busy     = (state_q == SHIFT);
    assign bus.done     = (state_q == DONE);
    assign bus.data_out = dout_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - randomized self-checking bench for shift_seq_ctrl against a plain-arithmetic model
module tb_shift_seq_ctrl;
    logic clock;
    logic reset_n;
    int   checks;
    int   failures;

    shift_seq_ctrl_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_seq_ctrl #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic dir);
        if (!dir) return d << sh;
`ifdef SHIFT_SEQ_ARITH_EN
        return $unsigned($signed(d) >>> sh);
`else
        return d >> sh;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive start for one cycle from the current cycle, then count edges until done (-1 on timeout).
    task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic dir,
                          output int lat, output logic [31:0] res);
        bus.start = 1'b1;
        bus.data_in = d;
        bus.shamt = sh;
        bus.ctrl_shiftdirection = dir;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            bus.start = 1'b0;
            bus.data_in = $urandom;
            bus.shamt = 5'($urandom);
            bus.ctrl_shiftdirection = 1'($urandom);
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        res = bus.data_out;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b data_out=%h required 0 0 00000000",
                     bus.busy, bus.done, bus.data_out);
        end
    endtask

    task automatic test_left();
        int lat; logic [31:0] res;
        run_op(32'h000D61A6, 5'd8, 1'b0, lat, res);
        checks++;
        if (res !== 32'h0D61A600) begin
            failures++; $display("FAIL left_result got %h required 0d61a600", res);
        end
        checks++;
        if (lat !== 6) begin
            failures++; $display("FAIL left_latency got %0d required 6", lat);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.data_out !== 32'h0D61A600) begin
            failures++;
            $display("FAIL done_pulse_hold done=%b data_out=%h required 0 0d61a600", bus.done, bus.data_out);
        end
    endtask

    task automatic test_right();
        int lat; logic [31:0] res; logic [31:0] exp;
`ifdef SHIFT_SEQ_ARITH_EN
        exp = 32'hF8000001;
`else
        exp = 32'h08000001;
`endif
        run_op(32'h80000010, 5'd4, 1'b1, lat, res);
        checks++;
        if (res !== exp || lat !== 6) begin
            failures++; $display("FAIL right_result got %h lat %0d required %h lat 6", res, lat, exp);
        end
    endtask

    task automatic test_extremes();
        int lat; logic [31:0] res;
        run_op(32'h00000001, 5'd31, 1'b0, lat, res);
        checks++;
        if (res !== 32'h80000000 || lat !== 6) begin
            failures++; $display("FAIL shamt31 got %h lat %0d required 80000000 lat 6", res, lat);
        end
        run_op(32'hDEADBEEF, 5'd0, 1'b1, lat, res);
        checks++;
        if (res !== 32'hDEADBEEF || lat !== 6) begin
            failures++; $display("FAIL shamt0 got %h lat %0d required deadbeef lat 6", res, lat);
        end
    endtask

    task automatic test_busy_ignore();
        int lat; logic [31:0] res;
        bus.start = 1'b1; bus.data_in = 32'h0000F00F; bus.shamt = 5'd3; bus.ctrl_shiftdirection = 1'b0;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL busy_high got %b required 1", bus.busy);
        end
        step();
        lat = -1;
        // A second request mid-operation must be dropped.
        run_op(32'hFFFFFFFF, 5'd17, 1'b1, lat, res);
        checks++;
        if (res !== 32'h0007807_8 || lat !== 4) begin
            failures++; $display("FAIL busy_ignore got %h lat %0d required 00078078 lat 4", res, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic [31:0] a, b, ea, eb;
        a = $urandom; b = $urandom;
        ea = ref_shift(a, 13, 1'b1);
        eb = ref_shift(b, 6, 1'b0);
        run_op(a, 5'd13, 1'b1, lat, res);
        checks++;
        if (res !== ea || lat !== 6) begin
            failures++; $display("FAIL b2b_first got %h lat %0d required %h lat 6", res, lat, ea);
        end
        run_op(b, 5'd6, 1'b0, lat, res);
        checks++;
        if (res !== eb || lat !== 6) begin
            failures++; $display("FAIL b2b_second got %h lat %0d required %h lat 6", res, lat, eb);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res;
        bus.start = 1'b1; bus.data_in = 32'h12345678; bus.shamt = 5'd2; bus.ctrl_shiftdirection = 1'b0;
        step();
        bus.start = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid busy=%b done=%b data_out=%h required 0 0 00000000",
                     bus.busy, bus.done, bus.data_out);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_no_done done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
        run_op(32'h0000ABCD, 5'd12, 1'b0, lat, res);
        checks++;
        if (res !== 32'hABCD000 || lat !== 6) begin
            failures++; $display("FAIL after_reset got %h lat %0d required 0abcd000 lat 6", res, lat);
        end
        step();
    endtask

    task automatic test_sweep();
        int lat; logic [31:0] res; logic [31:0] d; logic [31:0] exp;
        for (int dir = 0; dir < 2; dir++) begin
            for (int sh = 0; sh < 32; sh++) begin
                d = $urandom;
                if (sh[0]) d[31] = 1'b1;
                exp = ref_shift(d, sh, 1'(dir));
                run_op(d, 5'(sh), 1'(dir), lat, res);
                checks++;
                if (res !== exp || lat !== 6) begin
                    failures++;
                    $display("FAIL sweep dir=%0d sh=%0d data=%h got %h lat %0d required %h lat 6",
                             dir, sh, d, res, lat, exp);
                end
                if (sh[1]) step();
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.data_in = '0;
        bus.shamt = '0;
        bus.ctrl_shiftdirection = 1'b0;
        step();
        step();
        test_reset();
        reset_n = 1'b1;
        step();
        test_reset();
        test_left();
        test_right();
        test_extremes();
        step();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
